// File: rtl/elm_ctrl_pkg.sv
// elm_ctrl_pkg: shared state encoding and constants for the ELM layer sequencer
package elm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NRST,
        S_LOAD_W,
        S_LOAD_B,
        S_CAPTURE,
        S_BURST,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam logic [63:0] CFG_NONE = '1;
    localparam int NRST_CYCLES = 2;

endpackage

// File: rtl/elm_vec_buffer.sv
// elm_vec_buffer: single-port input-vector RAM with registered read data
module elm_vec_buffer
    import elm_ctrl_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int W = 16,
    parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // storage write; the array itself needs no reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // registered read port, cleared on reset so the broadcast bus idles at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/elm_layer_ctrl.sv
// elm_layer_ctrl: weight load, input broadcast and result drain for one ELM layer (option ELM_LAYER_CTRL_TIMEOUT_EN)
module elm_layer_ctrl
    import elm_ctrl_pkg::*;
#(
    parameter int LAYER_NO = 1,
    parameter int NUM_NEURON = 128,
    parameter int NUM_WEIGHT = 128,
    parameter int DATA_W = 16,
    parameter int OUT_W = 16,
    parameter int CFG_W = 2 * DATA_W + 1
`ifdef ELM_LAYER_CTRL_TIMEOUT_EN
    , parameter int WAIT_TIMEOUT = 1024
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_w_valid,
    output logic                        s_w_ready,
    input  logic [DATA_W-1:0]           s_w_data,
    input  logic                        s_x_valid,
    output logic                        s_x_ready,
    input  logic [DATA_W-1:0]           s_x_data,
    output logic                        n_rst,
    output logic                        n_weight_valid,
    output logic [NUM_NEURON-1:0]       n_bias_valid,
    output logic [DATA_W-1:0]           n_value,
    output logic [CFG_W-1:0]            n_cfg_layer,
    output logic [CFG_W-1:0]            n_cfg_neuron,
    output logic                        n_input_valid,
    output logic [DATA_W-1:0]           n_input,
    input  logic [NUM_NEURON-1:0]       n_outvalid,
    input  logic [NUM_NEURON*OUT_W-1:0] n_out,
    output logic                        m_y_valid,
    input  logic                        m_y_ready,
    output logic [OUT_W-1:0]            m_y_data,
    output logic                        m_y_last,
    output logic                        loaded,
    output logic                        busy
`ifdef ELM_LAYER_CTRL_TIMEOUT_EN
    , output logic                      timeout_err
`endif
);

    localparam int CW = $clog2(NUM_WEIGHT + 1);
    localparam int KW = $clog2(NUM_NEURON + 1);
    localparam int NAW = NUM_NEURON > 1 ? $clog2(NUM_NEURON) : 1;
    localparam int BAW = NUM_WEIGHT > 1 ? $clog2(NUM_WEIGHT) : 1;
    localparam logic [CW-1:0] W_LAST = CW'(NUM_WEIGHT - 1);
    localparam logic [CW-1:0] R_LAST = CW'(NRST_CYCLES - 1);
    localparam logic [KW-1:0] N_LAST = KW'(NUM_NEURON - 1);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k;
    logic [NUM_NEURON-1:0] done;
    logic [OUT_W-1:0] result [NUM_NEURON];
    logic wait_done;
    logic buf_we;

    assign n_cfg_layer = CFG_W'(LAYER_NO);
    assign busy = state != S_IDLE;
    assign buf_we = state == S_CAPTURE && s_x_valid;

`ifdef ELM_LAYER_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(WAIT_TIMEOUT - 1);
    logic [TW-1:0] tcnt;
    assign wait_done = (&done) || tcnt == T_LAST;
    // watchdog on WAIT; a forced exit with neurons missing latches the error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt <= state == S_WAIT ? tcnt + 1'b1 : '0;
            if (state == S_WAIT && tcnt == T_LAST && !(&done)) timeout_err <= 1'b1;
        end
    end
`else
    assign wait_done = &done;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else state <= nxt;
    end

    // next state plus handshake and stream outputs decoded from the current state
    always_comb begin
        nxt = state;
        s_w_ready = 1'b0;
        s_x_ready = 1'b0;
        n_rst = 1'b0;
        m_y_valid = 1'b0;
        m_y_last = 1'b0;
        m_y_data = result[k[NAW-1:0]];
        case (state)
            S_IDLE: nxt = s_w_valid ? S_NRST : (s_x_valid && loaded) ? S_CAPTURE : S_IDLE;
            S_NRST: begin
                n_rst = 1'b1;
                nxt = cnt == R_LAST ? S_LOAD_W : S_NRST;
            end
            S_LOAD_W: begin
                s_w_ready = 1'b1;
                nxt = (s_w_valid && cnt == W_LAST) ? S_LOAD_B : S_LOAD_W;
            end
            S_LOAD_B: begin
                s_w_ready = 1'b1;
                nxt = !s_w_valid ? S_LOAD_B : k == N_LAST ? S_IDLE : S_LOAD_W;
            end
            S_CAPTURE: begin
                s_x_ready = 1'b1;
                nxt = (s_x_valid && cnt == W_LAST) ? S_BURST : S_CAPTURE;
            end
            S_BURST: nxt = cnt == W_LAST ? S_WAIT : S_BURST;
            S_WAIT: nxt = wait_done ? S_DRAIN : S_WAIT;
            S_DRAIN: begin
                m_y_valid = 1'b1;
                m_y_last = k == N_LAST;
                nxt = (m_y_ready && k == N_LAST) ? S_IDLE : S_DRAIN;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // word counter restarts on every state change; neuron index serves both load and drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            k <= '0;
            loaded <= 1'b0;
        end else begin
            cnt <= state != nxt ? '0 :
                   (state == S_NRST || state == S_BURST || (state == S_LOAD_W && s_w_valid) || buf_we) ? cnt + 1'b1 : cnt;
            k <= (state == S_IDLE || state == S_NRST || state == S_WAIT) ? '0 :
                 (((state == S_LOAD_B && s_w_valid) || (state == S_DRAIN && m_y_ready)) && k != N_LAST) ? k + 1'b1 : k;
            loaded <= state == S_NRST ? 1'b0 : (state == S_LOAD_B && s_w_valid && k == N_LAST) ? 1'b1 : loaded;
        end
    end

    // neuron-side strobes lag the accepted beat by one cycle; select parks at all-ones when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_weight_valid <= 1'b0;
            n_bias_valid <= '0;
            n_value <= '0;
            n_cfg_neuron <= CFG_NONE[CFG_W-1:0];
            n_input_valid <= 1'b0;
        end else begin
            n_weight_valid <= state == S_LOAD_W && s_w_valid;
            n_bias_valid <= (state == S_LOAD_B && s_w_valid) ? NUM_NEURON'(1) << k : '0;
            n_value <= (s_w_ready && s_w_valid) ? s_w_data : n_value;
            n_cfg_neuron <= (s_w_ready && s_w_valid) ? CFG_W'(k) : state == S_IDLE ? CFG_NONE[CFG_W-1:0] : n_cfg_neuron;
            n_input_valid <= state == S_BURST;
        end
    end

    // sticky completion vector and result capture; results zeroed per burst so absent neurons read 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= '0;
            for (int i = 0; i < NUM_NEURON; i++) result[i] <= '0;
        end else begin
            done <= state == S_WAIT ? done | n_outvalid : state == S_DRAIN ? done : '0;
            for (int i = 0; i < NUM_NEURON; i++)
                result[i] <= state == S_BURST ? '0 :
                             (state == S_WAIT && n_outvalid[i]) ? n_out[i*OUT_W +: OUT_W] : result[i];
        end
    end

    elm_vec_buffer #(.DEPTH(NUM_WEIGHT), .W(DATA_W), .AW(BAW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .re    (state == S_BURST),
        .addr  (cnt[BAW-1:0]),
        .wdata (s_x_data),
        .rdata (n_input)
    );

endmodule

// File: tb/tb_elm_layer_ctrl.sv
// tb_elm_layer_ctrl: directed bench for elm_layer_ctrl with a 4x4 layer
module tb_elm_layer_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic s_w_valid, s_w_ready, s_x_valid, s_x_ready;
    logic [15:0] s_w_data, s_x_data;
    logic n_rst, n_weight_valid, n_input_valid;
    logic [3:0] n_bias_valid, n_outvalid;
    logic [15:0] n_value, n_input;
    logic [32:0] n_cfg_layer, n_cfg_neuron;
    logic [63:0] n_out;
    logic m_y_valid, m_y_ready, m_y_last, loaded, busy;
    logic [15:0] m_y_data;
`ifdef ELM_LAYER_CTRL_TIMEOUT_EN
    logic timeout_err;
`endif

    int passed = 0, total = 0, fails = 0, to_err = 0;
    int cyc = 0, nrst_n = 0;
    logic [15:0] wv[$], bval[$], iv[$];
    logic [32:0] wn[$], bn[$];
    logic [3:0] bv[$];
    int icyc[$];

    always #5 clk = ~clk;

    elm_layer_ctrl #(.NUM_NEURON(4), .NUM_WEIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_x_valid(s_x_valid), .s_x_ready(s_x_ready), .s_x_data(s_x_data),
        .n_rst(n_rst), .n_weight_valid(n_weight_valid), .n_bias_valid(n_bias_valid),
        .n_value(n_value), .n_cfg_layer(n_cfg_layer), .n_cfg_neuron(n_cfg_neuron),
        .n_input_valid(n_input_valid), .n_input(n_input),
        .n_outvalid(n_outvalid), .n_out(n_out),
        .m_y_valid(m_y_valid), .m_y_ready(m_y_ready), .m_y_data(m_y_data), .m_y_last(m_y_last),
        .loaded(loaded), .busy(busy)
`ifdef ELM_LAYER_CTRL_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    // record every neuron-side strobe away from the clock edge
    always @(negedge clk) begin
        cyc++;
        if (n_rst) nrst_n++;
        if (n_weight_valid) begin wv.push_back(n_value); wn.push_back(n_cfg_neuron); end
        if (|n_bias_valid) begin bv.push_back(n_bias_valid); bval.push_back(n_value); bn.push_back(n_cfg_neuron); end
        if (n_input_valid) begin iv.push_back(n_input); icyc.push_back(cyc); end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_w(input logic [15:0] d);
        int t = 0;
        s_w_valid = 1'b1;
        s_w_data = d;
        while (!s_w_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) to_err++;
        @(negedge clk);
        s_w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [15:0] d);
        int t = 0;
        s_x_valid = 1'b1;
        s_x_data = d;
        while (!s_x_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) to_err++;
        @(negedge clk);
        s_x_valid = 1'b0;
    endtask

    task automatic load_all(input int base);
        for (int n = 0; n < 4; n++) begin
            for (int w = 0; w < 5; w++) begin
                send_w(w < 4 ? 16'(base + 4 * n + w + 1) : 16'(100 + base + n));
                s_x_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
    endtask

    task automatic pulse(input int i, input logic [15:0] v);
        n_out = '1;
        n_out[i*16 +: 16] = v;
        n_outvalid = 4'(1 << i);
        @(negedge clk);
        n_outvalid = '0;
        n_out = '1;
    endtask

    initial begin
        rst = 1'b1;
        {s_w_valid, s_x_valid, m_y_ready} = '0;
        s_w_data = '0;
        s_x_data = '0;
        n_outvalid = '0;
        n_out = '1;
        repeat (2) @(negedge clk);
        chk("rst_cfg_neuron", n_cfg_neuron, 64'h1_FFFF_FFFF);
        chk("rst_ctrl", {loaded, busy, n_rst, n_weight_valid, n_input_valid, m_y_valid, m_y_last, s_w_ready, s_x_ready, n_bias_valid}, 0);
        chk("rst_data", {n_value, n_input, m_y_data}, 0);
        rst = 1'b0;
        @(negedge clk);

        s_x_valid = 1'b1;
        s_x_data = 16'd9;
        repeat (3) @(negedge clk);
        chk("x_ready_unloaded", {s_x_ready, busy}, 0);

        load_all(0);
        repeat (2) @(negedge clk);
        chk("nrst_cycles", nrst_n, 2);
        chk("cfg_layer", n_cfg_layer, 1);
        chk("weight_count", wv.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("weight%0d", i), {wn[i], wv[i]}, {33'(i / 4), 16'(i + 1)});
        chk("bias_count", bv.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bias%0d", i), {bn[i], bv[i], bval[i]}, {33'(i), 4'(1 << i), 16'(100 + i)});
        chk("loaded_idle", {loaded, busy}, 2'b10);
        chk("cfg_none_after_load", n_cfg_neuron, 64'h1_FFFF_FFFF);

        send_x(16'd5);
        send_x(16'd6);
        repeat (3) @(negedge clk);
        send_x(16'd7);
        send_x(16'd8);
        repeat (8) @(negedge clk);
        chk("burst_len", iv.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("burst%0d", i), iv[i], 16'(5 + i));
        chk("burst_gapfree", icyc[3] - icyc[0], 3);

        pulse(3, 16'h13);
        pulse(0, 16'h10);
        pulse(2, 16'h12);
        chk("no_drain_early", m_y_valid, 0);
        pulse(1, 16'h11);
        @(negedge clk);
        chk("y0", {m_y_valid, m_y_last, m_y_data}, {1'b1, 1'b0, 16'h10});
        m_y_ready = 1'b1;
        @(negedge clk);
        chk("y1", {m_y_valid, m_y_last, m_y_data}, {1'b1, 1'b0, 16'h11});
        m_y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("y1_stall%0d", i), {m_y_valid, m_y_last, m_y_data}, {1'b1, 1'b0, 16'h11});
        end
        m_y_ready = 1'b1;
        @(negedge clk);
        chk("y2", {m_y_valid, m_y_last, m_y_data}, {1'b1, 1'b0, 16'h12});
        @(negedge clk);
        chk("y3_last", {m_y_valid, m_y_last, m_y_data}, {1'b1, 1'b1, 16'h13});
        @(negedge clk);
        chk("drain_done", {m_y_valid, busy}, 0);
        m_y_ready = 1'b0;

        for (int i = 1; i <= 4; i++) send_x(16'(i));
        @(negedge clk);
        chk("burst_running", {n_input_valid, n_input}, {1'b1, 16'd1});
        #2 rst = 1'b1;
        #1;
        chk("abort_ctrl", {n_input_valid, busy, loaded, m_y_valid, s_x_ready, s_w_ready, n_rst}, 0);
        chk("abort_data", {n_input, n_cfg_neuron}, {16'd0, 33'h1_FFFF_FFFF});
        @(negedge clk);
        rst = 1'b0;
        s_x_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("x_ready_after_abort", {s_x_ready, busy, loaded}, 0);
        s_x_valid = 1'b0;

`ifdef ELM_LAYER_CTRL_TIMEOUT_EN
        chk("timeout_clear", timeout_err, 0);
        load_all(32);
        for (int i = 1; i <= 4; i++) send_x(16'(i));
        repeat (6) @(negedge clk);
        pulse(0, 16'h20);
        pulse(1, 16'h21);
        pulse(3, 16'h23);
        begin
            int t = 0;
            while (!m_y_valid && t < 1100) begin @(negedge clk); t++; end
            chk("timeout_drain_reached", m_y_valid, 1);
        end
        chk("timeout_err", timeout_err, 1);
        chk("to_y0", m_y_data, 16'h20);
        m_y_ready = 1'b1;
        @(negedge clk);
        chk("to_y1", m_y_data, 16'h21);
        @(negedge clk);
        chk("to_y2_missing", m_y_data, 16'h0);
        @(negedge clk);
        chk("to_y3", {m_y_last, m_y_data}, {1'b1, 16'h23});
        @(negedge clk);
        m_y_ready = 1'b0;
`endif

        chk("handshake_timeouts", to_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/elm_layer_ctrl.md
Name: elm_layer_ctrl

Overview:
Sequencer for one ELM hidden layer built from NUM_NEURON parallel neuron instances.
- Load phase: streams weights and biases into the neurons using the layer/neuron select bus, neuron 0 first.
- Inference phase: buffers one input vector, then broadcasts it to all neurons as one gap-free burst.
- Collects each neuron's activation on its outvalid and drains the results as an output stream.
- Sits between the AXI-side DMA/FIFO logic and the neuron array.

Parameters:
LAYER_NO, 1, constant driven on n_cfg_layer.
NUM_NEURON, 128, number of neurons in the layer.
NUM_WEIGHT, 128, weights per neuron, which is also the input vector length.
DATA_W, 16, width of weight, bias and input words (`dataWidth).
OUT_W, 16, neuron activation width (`ROM_bitwidth).
CFG_W, 2*DATA_W+1, width of the layer/neuron select bus.
WAIT_TIMEOUT, 1024, watchdog limit in cycles (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_w_valid/s_w_ready/s_w_data  in/out/in  1/1/DATA_W  weight stream; per neuron, NUM_WEIGHT weights then 1 bias
s_x_valid/s_x_ready/s_x_data  in/out/in  1/1/DATA_W  input-vector stream, NUM_WEIGHT words per vector
n_rst  out  1  synchronous reset to the neuron array
n_weight_valid  out  1  weight strobe
n_bias_valid  out  NUM_NEURON  one-hot bias strobe
n_value  out  DATA_W  weight or bias value
n_cfg_layer, n_cfg_neuron  out  CFG_W  neuron select
n_input_valid, n_input  out  1, DATA_W  input broadcast
n_outvalid  in  NUM_NEURON  per-neuron result valid
n_out  in  NUM_NEURON*OUT_W  flattened activations, neuron i at [i*OUT_W +: OUT_W]
m_y_valid/m_y_ready/m_y_data/m_y_last  out/in/out/out  1/1/OUT_W/1  result stream
loaded  out  1  a full weight set is resident
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0 except n_cfg_neuron = all-ones (matches no neuron); FSM = IDLE; loaded = 0.
- States: IDLE, NRST, LOAD_W, LOAD_B, CAPTURE, BURST, WAIT, DRAIN.
- IDLE transitions:
  - s_w_valid -> NRST. Weight load has priority when both streams are valid.
  - else s_x_valid & loaded -> CAPTURE.
  - s_x_ready = 0 while loaded = 0.
- NRST:
  - n_rst high for exactly 2 cycles, so neuron write addresses return to all-ones.
  - Clears loaded and neuron index k.
  - -> LOAD_W.
- LOAD_W:
  - s_w_ready = 1.
  - Each accepted beat is registered onto n_value/n_weight_valid one cycle later, with n_cfg_neuron = k.
  - After NUM_WEIGHT beats -> LOAD_B.
- LOAD_B:
  - One accepted beat drives n_bias_valid[k] for 1 cycle; n_cfg_neuron keeps k.
  - If k == NUM_NEURON-1: -> IDLE, loaded = 1, n_cfg_neuron returns to all-ones.
  - Else k++ and -> LOAD_W.
- Weight stream stalls (s_w_valid low) simply pause the state machine; no strobes are issued during a stall.
- CAPTURE:
  - s_x_ready = 1; words are written into an internal NUM_WEIGHT x DATA_W buffer.
  - After NUM_WEIGHT words -> BURST.
- BURST:
  - n_input_valid high for exactly NUM_WEIGHT consecutive cycles.
  - n_input = buffer[j], j = 0..NUM_WEIGHT-1, from a registered read with no gaps.
  - -> WAIT.
- WAIT:
  - Sticky done vector: done[i] |= n_outvalid[i].
  - n_out[i] is captured into a result register on the same cycle n_outvalid[i] is high.
  - When done is all-ones -> DRAIN.
  - An n_outvalid arriving outside WAIT is ignored.
- DRAIN:
  - m_y_data = result[i] for i = 0..NUM_NEURON-1; m_y_last at i == NUM_NEURON-1.
  - m_y_valid/data are held stable until m_y_ready; the next word is presented the cycle after the handshake.
  - After the last handshake -> IDLE with the done vector cleared.
- busy = (state != IDLE).
- Async rst in any state aborts immediately to the reset values; loaded = 0, so weights must be reloaded.
- Counters are sized $clog2(N+1); there is no wrap-around in any state.

Optional Feature:
ELM_LAYER_CTRL_TIMEOUT_EN
- Defined:
  - A WAIT cycle counter; reaching WAIT_TIMEOUT forces DRAIN.
  - Missing neurons drain as 0.
  - Sticky output timeout_err (1 bit, extra port) is set and cleared only by rst.
- Undefined: no counter and no port; WAIT can last indefinitely.

Decomposition:
- Package elm_ctrl_pkg:
  - state encoding constants;
  - CFG_NONE (all-ones select value);
  - NRST_CYCLES = 2.
- One natural sub-module: elm_vec_buffer, a single-port NUM_WEIGHT x DATA_W RAM with a registered read port, used by CAPTURE/BURST.

Test Plan:
- Load NUM_NEURON=4, NUM_WEIGHT=4, weights 1..16, biases 100..103 with random s_w_valid gaps -> n_rst 2 cycles; 16 weight strobes; n_cfg_neuron = 0,0,0,0,1,...; n_bias_valid = 0001,0010,0100,1000 with n_value 100..103; loaded = 1.
- s_x words {5,6,7,8} with a 3-cycle gap mid-vector -> n_input_valid high exactly 4 consecutive cycles carrying 5,6,7,8.
- Model neurons pulse n_outvalid out of order (3,0,2,1) with values 0x10..0x13 -> m_y 0x10,0x11,0x12,0x13; m_y_last on the 4th word only.
- Hold m_y_ready low for 5 cycles mid-drain -> data stable, no word skipped or duplicated.
- s_x_valid while loaded = 0 -> s_x_ready stays 0; s_w_valid and s_x_valid together in IDLE -> NRST taken.
- Assert rst during BURST -> all outputs at reset values the same cycle; loaded = 0. With ELM_LAYER_CTRL_TIMEOUT_EN, withhold neuron 2's outvalid -> after 1024 WAIT cycles result[2] = 0 and timeout_err = 1.
